// File: rtl/vga_timing.sv
// 800x600 raster timing generator: free-running h/v counters with a single
// registered decode stage so every output describes the same pixel.
module vga_timing #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FRONT   = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FRONT   = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 23,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_BEG  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END  = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned VS_BEG  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END  = V_VISIBLE + V_FRONT + V_SYNC;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic       active_c;
    logic       hs_act_c;
    logic       vs_act_c;
    logic [9:0] row_c;
    logic [9:0] col_c;
    logic       line_start_c;
    logic       frame_start_c;

    // Raster position counters; vertical steps on each horizontal wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Decode of the current counter position, registered below.
    always_comb begin
        active_c      = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
        hs_act_c      = (h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END));
        vs_act_c      = (v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END));
        row_c         = active_c ? v_cnt[9:0] : 10'd0;
        col_c         = active_c ? h_cnt[9:0] : 10'd0;
        line_start_c  = (h_cnt == '0);
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    end

    // Output stage: loads on enabled cycles, pulses drop whenever en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            row         <= row_c;
            col         <= col_c;
            hsync       <= hs_act_c ? HS_POL : ~HS_POL;
            vsync       <= vs_act_c ? VS_POL : ~VS_POL;
            blank       <= ~active_c;
            line_start  <= line_start_c;
            frame_start <= frame_start_c;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
